store_bus_arbiter: RTL
======================

Name: store_bus_arbiter

Overview:
- Shares one execute-to-store bus between NUM_REQ execute-stage requesters (lanes or cores).
- Round-robin arbitration at packet granularity. A multi-beat packet (e.g. a two-address conditional jump) keeps its grant until its last beat.
- Provides a one-entry registered output toward the store stage, which backpressures through out_busy, matching the store-bus is_busy semantics.

Parameters:
- NUM_REQ, 4, number of requesting execute stages (2..8).
- PKT_W, 256, width of one store-bus beat (mask, PC, storage opcode, operands packed).
- SRC_W, 3, width of source-ID field; must satisfy 2**SRC_W >= NUM_REQ.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  beat is final beat of its packet
- req_pkt  in  NUM_REQ*PKT_W  per-requester beat; requester i occupies bits [i*PKT_W +: PKT_W]
- req_ready  out  NUM_REQ  beat accepted this cycle when req_valid[i] && req_ready[i]
- out_valid  out  1  output register holds a beat
- out_pkt  out  PKT_W  beat to store stage
- out_src  out  SRC_W  requester index of out_pkt
- out_last  out  1  last-beat flag of out_pkt
- out_busy  in  1  store stage busy; beat consumed when out_valid && !out_busy
- locked  out  1  a multi-beat packet owns the bus

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: out_valid=0, out_pkt=0, out_src=0, out_last=0, locked=0, req_ready=0, rr_ptr=0, owner=0.
- can_load = !out_valid || !out_busy. The output register may capture a beat in the same cycle the previous one drains.
- States: IDLE (no owner), LOCK (owner holds the bus mid-packet).
- IDLE:
  - winner = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner] = can_load. All other ready bits are 0.
  - On transfer with req_last=1: stay IDLE, rr_ptr <= winner+1 (wrapping).
  - On transfer with req_last=0: go to LOCK, owner <= winner, locked <= 1.
- LOCK:
  - req_ready[owner] = can_load. All other ready bits are 0, even when the owner is not valid (bubbles are allowed; no preemption).
  - On owner transfer with req_last=1: go to IDLE, locked <= 0, rr_ptr <= owner+1.
- Transfer: out_pkt, out_src and out_last <= the selected requester's values; out_valid <= 1.
- Drain without refill: out_valid <= 0 when out_valid && !out_busy and no transfer occurs.
- req_ready is combinational from state, req_valid, rr_ptr, out_valid and out_busy. It must not depend on req_pkt.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1. Sustained throughput is 1 beat/cycle while out_busy=0.
- out_pkt and out_src must hold stable while out_valid && out_busy.
- Fairness: any continuously valid requester is granted within NUM_REQ-1 packets from others.
- Boundaries:
  - No valid requesters: ready all 0, state unchanged, rr_ptr unchanged.
  - rr_ptr=NUM_REQ-1 with only requester 0 valid: requester 0 wins (wrap).
  - out_busy held high: no ready asserted once out_valid=1. No beat may be lost or duplicated.
  - Reset mid-packet (LOCK): returns to IDLE and out_valid=0; the partial packet is discarded. Requesters re-send after reset.
  - req_last=1 on the first beat is a single-beat packet; LOCK is never entered.

Test Plan:
- Reset, then valid=4'b1111, all last=1, out_busy=0 -> grants 0,1,2,3,0 on consecutive cycles; out_src 0,1,2,3 one cycle later.
- rr_ptr=3 (after a grant to requester 2), valid=4'b0001 -> requester 0 granted; next rr_ptr=1.
- Requester 1 sends a 2-beat packet (last=0 then 1) while 0 and 2 are valid -> out_src=1,1 back-to-back, locked=1 for one cycle, then requester 2 granted.
- out_busy=1 for 5 cycles with valid=4'b0011 -> out_pkt held constant, ready=0 after the first load; on release the next beat follows immediately, with no loss or duplication (scoreboard check).
- Reset asserted in LOCK after the first beat of a 2-beat packet from requester 3 -> next cycle out_valid=0, locked=0, rr_ptr=0; new arbitration starts at requester 0.
- Requester 2 in LOCK deasserts valid for 3 cycles while 0 and 1 are valid -> no grants to 0/1 until requester 2's last beat; then requester 0 is granted (wrap from rr_ptr=3).

Source files
------------

// File: rtl/store_bus_arbiter.sv
// Round-robin arbiter sharing one execute-to-store bus between NUM_REQ lanes.
// Multi-beat packets hold the grant until their last beat; one-entry output register.
module store_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = 256,
  parameter int SRC_W   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [PKT_W-1:0]         out_pkt,
  output logic [SRC_W-1:0]         out_src,
  output logic                     out_last,
  input  logic                     out_busy,
  output logic                     locked
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             r_state;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   r_owner;
  logic               r_locked;
  logic               r_out_valid;
  logic [PKT_W-1:0]   r_out_pkt;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_out_last;

  logic               w_can_load;
  logic               w_found;
  logic [SRC_W-1:0]   w_win;
  logic [SRC_W:0]     w_idx;
  logic [SRC_W-1:0]   w_sel;
  logic               w_grant;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [PKT_W-1:0]   w_sel_pkt;
  logic               w_xfer;

  function automatic logic [SRC_W-1:0] f_inc(input logic [SRC_W-1:0] x);
    return (x == SRC_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  assign w_can_load = !r_out_valid || !out_busy;

  // First valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
      if (w_idx >= (SRC_W+1)'(NUM_REQ))
        w_idx = w_idx - (SRC_W+1)'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && w_idx == (SRC_W+1)'(j) && req_valid[j]) begin
          w_found = 1'b1;
          w_win   = SRC_W'(j);
        end
      end
    end
  end

  assign w_sel   = (r_state == LOCK) ? r_owner : w_win;
  assign w_grant = (r_state == LOCK) || w_found;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_pkt   = '0;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == SRC_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_pkt   = req_pkt[i*PKT_W +: PKT_W];
      end
      req_ready[i] = !reset && w_grant && w_can_load
                     && (w_sel == SRC_W'(i));
    end
  end

  assign w_xfer = w_grant && w_can_load && w_sel_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_locked    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pkt   <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_pkt   <= w_sel_pkt;
        r_out_src   <= w_sel;
        r_out_last  <= w_sel_last;
      end else if (r_out_valid && !out_busy) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (w_xfer && w_sel_last) begin
            r_rr_ptr <= f_inc(w_win);
          end else if (w_xfer) begin
            r_state  <= LOCK;
            r_owner  <= w_win;
            r_locked <= 1'b1;
          end
        end
        LOCK: begin
          if (w_xfer && w_sel_last) begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_rr_ptr <= f_inc(r_owner);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_pkt   = r_out_pkt;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;
  assign locked    = r_locked;

endmodule
